// File: rtl/dice_display.sv
// Display stage for the dice roller: decodes the two BCD result digits onto a
// multiplexed 2-digit 7-segment display and tracks rolling/settled activity.
module dice_display #(
  parameter int unsigned SCAN_DIV      = 64,
  parameter int unsigned GUARD         = 2,
  parameter int unsigned SETTLE_CYCLES = 8192,
  parameter int unsigned BLINK_DIV     = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] digit10,
  input  logic [3:0] digit1,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_sel,
  output logic       rolling,
  output logic       settled
);

  localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BLINK_W  = $clog2(BLINK_DIV + 1);
  localparam int unsigned HALF_W   = 3;
  localparam int unsigned HALVES   = 6;

  typedef enum logic [1:0] {IDLE, ROLLING, RESULT, SHOW} state_t;

  state_t              state, state_nxt;
  logic [7:0]          prev;
  logic [SCAN_W-1:0]   scan_cnt, scan_nxt;
  logic                phase, phase_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [BLINK_W-1:0]  blink_sub, sub_nxt;
  logic [HALF_W-1:0]   blink_half, half_nxt;

  logic       change;
  logic       scan_wrap;
  logic       blink_off;
  logic       tens_blank;
  logic [6:0] seg_pat;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [1:0] dig_sel_nxt;
  logic       settled_nxt;

  // BCD to {g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are registered from these
  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle_cnt;
    sub_nxt     = blink_sub;
    half_nxt    = blink_half;
    settled_nxt = 1'b0;
    blink_off   = 1'b0;

    change    = {digit10, digit1} != prev;
    scan_wrap = scan_cnt == SCAN_W'(SCAN_DIV - 1);
    scan_nxt  = scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
    phase_nxt = phase ^ scan_wrap;

    case (state)
      IDLE, SHOW: begin
        if (change) begin
          state_nxt  = ROLLING;
          settle_nxt = '0;
        end
      end
      ROLLING: begin
        if (change) begin
          settle_nxt = '0;
        end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_nxt   = RESULT;
          settle_nxt  = '0;
          sub_nxt     = '0;
          half_nxt    = '0;
          settled_nxt = 1'b1;
        end else begin
          settle_nxt = settle_cnt + SETTLE_W'(1);
        end
      end
      RESULT: begin
        if (change) begin
          state_nxt  = ROLLING;
          settle_nxt = '0;
          sub_nxt    = '0;
          half_nxt   = '0;
        end else if (blink_half == HALF_W'(HALVES)) begin
          state_nxt = SHOW;
          sub_nxt   = '0;
          half_nxt  = '0;
        end else begin
          // even half-periods are the dark ones, so each blink starts off
          blink_off = ~blink_half[0];
          if (blink_sub == BLINK_W'(BLINK_DIV - 1)) begin
            sub_nxt  = '0;
            half_nxt = blink_half + HALF_W'(1);
          end else begin
            sub_nxt = blink_sub + BLINK_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!ena) begin
      state_nxt   = IDLE;
      scan_nxt    = '0;
      phase_nxt   = 1'b0;
      settle_nxt  = '0;
      sub_nxt     = '0;
      half_nxt    = '0;
      settled_nxt = 1'b0;
      blink_off   = 1'b0;
    end

    // tens blanking only when the ones digit is nonzero, so 100 reads "00"
    tens_blank = (digit10 == 4'd0) && (digit1 != 4'd0);
    if (phase_nxt) seg_pat = tens_blank ? 7'h00 : decode(digit10);
    else           seg_pat = decode(digit1);

    seg_nxt     = (ena && !blink_off) ? seg_pat : 7'h00;
    dp_nxt      = ena && (state_nxt == ROLLING) && !phase_nxt;
    dig_sel_nxt = (!ena || scan_nxt < SCAN_W'(GUARD)) ? 2'b00
                : (phase_nxt ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev       <= 8'h01;
      scan_cnt   <= '0;
      phase      <= 1'b0;
      settle_cnt <= '0;
      blink_sub  <= '0;
      blink_half <= '0;
      seg        <= 7'h00;
      dp         <= 1'b0;
      dig_sel    <= 2'b00;
      rolling    <= 1'b0;
      settled    <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= {digit10, digit1};
      scan_cnt   <= scan_nxt;
      phase      <= phase_nxt;
      settle_cnt <= settle_nxt;
      blink_sub  <= sub_nxt;
      blink_half <= half_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      dig_sel    <= dig_sel_nxt;
      rolling    <= (state_nxt == ROLLING);
      settled    <= settled_nxt;
    end
  end

endmodule

// File: tb/tb_dice_display.sv
// Bench for dice_display: directed sequences and a decode table, with every
// cycle also compared against an event-based reference model.
module tb_dice_display;

  localparam int unsigned SD = 8;
  localparam int unsigned G  = 2;
  localparam int unsigned S  = 40;
  localparam int unsigned B  = 10;

  logic       clk, rst_n, ena;
  logic [3:0] digit10, digit1;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dig_sel;
  logic       rolling, settled;

  int tests = 0;
  int fails = 0;

  dice_display #(
    .SCAN_DIV(SD), .GUARD(G), .SETTLE_CYCLES(S), .BLINK_DIV(B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digit10(digit10), .digit1(digit1),
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .rolling(rolling), .settled(settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: time since enable, since the last change, since settling
  logic [6:0]  lut [16];
  logic [7:0]  m_prev;
  logic [3:0]  m10, m1;
  int          en_t, quiet, age;
  bit          roll, settle_ev, boff, ph;
  logic [6:0]  e_seg;
  logic [1:0]  e_sel;
  logic [11:0] exp_v;

  initial begin
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
    lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
    lut[8] = 7'h7F; lut[9] = 7'h6F;
    for (int i = 10; i < 16; i++) lut[i] = 7'h40;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 8'h01; en_t = 0; quiet = 0; age = -1; roll = 0;
      exp_v = '0;
    end else begin
      m10 = digit10; m1 = digit1; settle_ev = 0;
      if (!ena) begin
        en_t = 0; quiet = 0; age = -1; roll = 0;
        exp_v = '0;
      end else begin
        en_t++;
        if ({m10, m1} != m_prev) begin
          roll = 1; quiet = 0; age = -1;
        end else if (roll) begin
          quiet++;
          if (quiet == S) begin roll = 0; age = 0; settle_ev = 1; end
        end else if (age >= 0) begin
          age++;
          if (age > 6 * B) age = -1;
        end
        ph   = ((en_t / SD) % 2) == 1;
        boff = (age >= 1) && (age <= 6 * B) && (((age - 1) / B) % 2 == 0);
        if (ph) e_seg = (m10 == 0 && m1 != 0) ? 7'h00 : lut[m10];
        else    e_seg = lut[m1];
        if (boff) e_seg = 7'h00;
        e_sel = ((en_t % SD) < G) ? 2'b00 : (ph ? 2'b10 : 2'b01);
        exp_v = {e_seg, roll && !ph, e_sel, roll, settle_ev};
      end
      m_prev = {m10, m1};
    end
    #1;
    check("model", {seg, dp, dig_sel, rolling, settled}, exp_v);
  end

  typedef struct {
    logic [3:0] d10;
    logic [3:0] d1;
    logic [6:0] ones;
    logic [6:0] tens;
  } dec_vec_t;

  dec_vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int hold, r;

    vecs[0] = '{4'd0,  4'd0,  7'h3F, 7'h3F};
    vecs[1] = '{4'd0,  4'hB,  7'h40, 7'h00};
    vecs[2] = '{4'd1,  4'd9,  7'h6F, 7'h06};
    vecs[3] = '{4'hC,  4'd3,  7'h4F, 7'h40};
    vecs[4] = '{4'd7,  4'd5,  7'h6D, 7'h07};
    vecs[5] = '{4'd2,  4'd8,  7'h7F, 7'h5B};
    vecs[6] = '{4'd4,  4'd6,  7'h7D, 7'h66};
    vecs[7] = '{4'd3,  4'd2,  7'h5B, 7'h4F};
    vecs[8] = '{4'd9,  4'd0,  7'h3F, 7'h6F};
    vecs[9] = '{4'hF,  4'hA,  7'h40, 7'h40};

    rst_n = 1'b0; ena = 1'b1; digit10 = 4'd0; digit1 = 4'd1;
    @(negedge clk);
    check("reset_outputs", {seg, dp, dig_sel, rolling, settled}, 12'h000);
    rst_n = 1'b1;

    // static 0,1: ones shows 1, tens blanked, guard at each phase start
    tick(1);
    check("t1_e1_sel", dig_sel, 2'b00);
    check("t1_e1_seg", seg, 7'h06);
    check("t1_rolling", rolling, 1'b0);
    tick(1);
    check("t1_e2_sel", dig_sel, 2'b01);
    check("t1_e2_seg", seg, 7'h06);
    tick(SD - 2);
    check("t1_tens_guard", dig_sel, 2'b00);
    check("t1_tens_blank", seg, 7'h00);
    tick(G);
    check("t1_tens_sel", dig_sel, 2'b10);
    check("t1_tens_seg", seg, 7'h00);
    tick(SD - G);
    check("t1_wrap_sel", dig_sel, 2'b00);
    check("t1_wrap_seg", seg, 7'h06);

    // roll then settle and blink
    @(negedge clk); digit10 = 4'd1; digit1 = 4'd9;
    tick(1);
    check("t2_rolling", rolling, 1'b1);
    @(negedge clk); digit1 = 4'd8;
    @(negedge clk); digit1 = 4'd7;
    tick(1);
    for (int k = 0; k < S - 1; k++) check("t2_wait", {rolling, settled}, 2'b10);
    tick(S - 1);
    check("t2_pre_settle", {rolling, settled}, 2'b10);
    tick(1);
    check("t2_settled", {rolling, settled}, 2'b01);
    tick(1);
    check("t2_blink_off", {seg, dp, settled}, 9'h000);
    tick(B);
    check("t2_blink_on", seg == 7'h06 || seg == 7'h07, 1'b1);
    tick(5 * B);
    for (int k = 0; k < 2 * SD; k++) begin
      if (dig_sel == 2'b01) check("t2_show_ones", seg, 7'h07);
      if (dig_sel == 2'b10) check("t2_show_tens", seg, 7'h06);
      check("t2_show_rolling", rolling, 1'b0);
      tick(1);
    end

    // change landing on the settle-complete edge
    @(negedge clk); digit10 = 4'd2; digit1 = 4'd3;
    tick(1);
    repeat (S - 1) @(posedge clk);
    @(negedge clk); digit1 = 4'd4;
    tick(1);
    check("t3_boundary", {rolling, settled}, 2'b10);
    tick(S - 1);
    check("t3_restart_wait", {rolling, settled}, 2'b10);
    tick(1);
    check("t3_restart_settle", {rolling, settled}, 2'b01);

    // decode table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); digit10 = vecs[i].d10; digit1 = vecs[i].d1;
      found = 0;
      for (int k = 0; k < 4 * SD && !found; k++) begin
        tick(1);
        if (dig_sel == 2'b01) found = 1;
      end
      check("dec_ones_seen", found, 1'b1);
      check("dec_ones", seg, vecs[i].ones);
      found = 0;
      for (int k = 0; k < 4 * SD && !found; k++) begin
        tick(1);
        if (dig_sel == 2'b10) found = 1;
      end
      check("dec_tens_seen", found, 1'b1);
      check("dec_tens", seg, vecs[i].tens);
    end

    // enable gating during the blink
    found = 0;
    for (int k = 0; k < S + 4 * SD && !found; k++) begin
      tick(1);
      if (settled) found = 1;
    end
    check("t5_settled_seen", found, 1'b1);
    tick(3);
    @(negedge clk); ena = 1'b0;
    tick(1);
    check("t5_ena_off", {seg, dp, dig_sel, rolling, settled}, 12'h000);
    tick(4);
    check("t5_ena_off_hold", {seg, dp, dig_sel, rolling, settled}, 12'h000);
    @(negedge clk); ena = 1'b1;
    tick(1);
    check("t5_resume_first", {dig_sel, rolling}, 3'b000);
    tick(1);
    check("t5_resume_sel", {dig_sel, rolling}, 3'b010);
    check("t5_resume_seg", seg, vecs[9].ones);

    // async reset between edges while rolling
    @(negedge clk); digit10 = 4'd5; digit1 = 4'd5;
    tick(1);
    check("t6_rolling", rolling, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset", {seg, dp, dig_sel, rolling, settled}, 12'h000);
    @(negedge clk); rst_n = 1'b1;

    // randomized activity checked by the model
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      @(negedge clk);
      if (r == 0) begin
        ena = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        ena = 1'b1;
        hold = $urandom_range(1, 20);
      end else begin
        digit10 = (r < 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        digit1  = 4'($urandom_range(0, 15));
        hold = (r < 5) ? $urandom_range(1, 4) : $urandom_range(S - 2, S + 7 * B);
      end
      repeat (hold) @(negedge clk);
    end
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
